// File: rtl/fetch_pkg.sv
// Shared types and parameter helpers for the bf8b instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Memory beats needed to assemble one instruction.
    function automatic int fetch_beats(input int inst_width, input int m_width);
        return inst_width / m_width;
    endfunction

    // Cache index width for a power-of-two line count.
    function automatic int fetch_idx_w(input int cell_cnt);
        return $clog2(cell_cnt);
    endfunction

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: one word per line, tag plus valid bit,
// whole-cache flush that takes priority over a coincident fill.
module icache_dm
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int CELL_CNT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  hit
);

    localparam int IDX_W = fetch_idx_w(CELL_CNT);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    logic [CELL_CNT-1:0]   valid_q;
    logic [TAG_W-1:0]      tag_q  [CELL_CNT];
    logic [DATA_WIDTH-1:0] data_q [CELL_CNT];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;

    assign idx = addr[IDX_W-1:0];
    assign tag = addr[ADDR_WIDTH-1:IDX_W];

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays have no reset; the valid bits alone decide
    // whether their contents are meaningful, which keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= data_in;
        end
    end

    // A lookup in the flush cycle must not see lines that are being wiped.
    assign hit      = valid_q[idx] && (tag_q[idx] == tag) && !flush;
    assign data_out = data_q[idx];

endmodule

// File: rtl/fetch_unit.sv
// Multi-beat instruction fetch with little-endian assembly; the direct-mapped
// cache is built only when FETCH_ICACHE_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int M_WIDTH    = 8,
    parameter int INST_WIDTH = 16,
    parameter int CELL_CNT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [M_WIDTH-1:0]    pc,
    input  logic                  flush,
    input  logic [M_WIDTH-1:0]    data_in,
    input  logic                  mem_ready,
    output logic [M_WIDTH-1:0]    addr,
    output logic                  mem_req,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic                  ready
);

    localparam int BEATS = fetch_beats(INST_WIDTH, M_WIDTH);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      beat_q, beat_d;
    logic [INST_WIDTH-1:0] asm_q, asm_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic                  ready_q, ready_d;

    logic                  xfer;
    logic                  last_beat;
    logic                  cache_we;
    logic                  cache_hit;
    logic [INST_WIDTH-1:0] cache_data;
    logic [INST_WIDTH-1:0] word;

    assign mem_req   = (state_q == MEM) && en;
    assign addr      = (state_q == MEM) ? pc + M_WIDTH'(beat_q) : pc;
    assign xfer      = mem_req && mem_ready;
    assign last_beat = (beat_q == LAST_BEAT);
    assign cache_we  = xfer && last_beat;

    // Assembly register with the incoming beat merged into its slot.
    always_comb begin
        word = asm_q;
        word[beat_q*M_WIDTH +: M_WIDTH] = data_in;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a value unassigned (no latches).
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        inst_d  = inst_q;
        ready_d = ready_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (cache_hit) begin
                        inst_d  = cache_data;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        beat_d  = '0;
                        state_d = MEM;
                    end
                end
            end
            MEM: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (xfer) begin
                    asm_d  = word;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        inst_d  = word;
                        ready_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!en) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            asm_q   <= '0;
            inst_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
            inst_q  <= inst_d;
            ready_q <= ready_d;
        end
    end

    assign inst_out = inst_q;
    assign ready    = ready_q;

`ifdef FETCH_ICACHE_EN
    icache_dm #(
        .DATA_WIDTH (INST_WIDTH),
        .ADDR_WIDTH (M_WIDTH),
        .CELL_CNT   (CELL_CNT)
    ) u_icache (
        .clk      (clk),
        .rst      (rst),
        .we       (cache_we),
        .flush    (flush),
        .addr     (pc),
        .data_in  (word),
        .data_out (cache_data),
        .hit      (cache_hit)
    );
`else
    logic unused_cache_inputs;
    assign unused_cache_inputs = flush ^ cache_we;
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; expectations adapt to whether
// FETCH_ICACHE_EN is defined for the build.
module tb_fetch_unit;

`ifdef FETCH_ICACHE_EN
    localparam bit C = 1'b1;
`else
    localparam bit C = 1'b0;
`endif
    localparam int BEATS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  pc;
    logic        flush;
    logic [7:0]  data_in;
    logic        mem_ready;
    logic [7:0]  addr;
    logic        mem_req;
    logic [15:0] inst_out;
    logic        ready;

    logic [7:0]  mem [256];

    int passed = 0;
    int total  = 0;

    // Results of the most recent fetch.
    int          r_edges, r_reqs, r_xf;
    logic [7:0]  r_a0, r_a1;
    bit          r_unstable;
    logic [15:0] r_inst;
    bit          r_rdy_fl;
    logic [15:0] r_inst_fl;

    fetch_unit #(.M_WIDTH(8), .INST_WIDTH(16), .CELL_CNT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .pc        (pc),
        .flush     (flush),
        .data_in   (data_in),
        .mem_ready (mem_ready),
        .addr      (addr),
        .mem_req   (mem_req),
        .inst_out  (inst_out),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    assign data_in = mem[addr];

    // Runs one fetch from IDLE (entered at posedge+1) and measures it; edges
    // counts clock edges from the first one that samples en high until ready.
    task automatic do_fetch(input logic [7:0] p, input int stall,
                            input bit fl_start, input bit fl_last, input bit fl_done);
        int stall_cnt = 0;
        logic [7:0] beat_addr = 8'h00;
        r_edges = 0; r_reqs = 0; r_xf = 0; r_a0 = 8'hxx; r_a1 = 8'hxx;
        r_unstable = 1'b0; r_rdy_fl = 1'b0; r_inst_fl = 16'h0;
        pc = p;
        en = 1'b1;
        flush = fl_start;
        while (ready !== 1'b1 && r_edges < 200) begin
            #1;
            mem_ready = 1'b0;
            if (mem_req === 1'b1) begin
                r_reqs++;
                if (stall_cnt == 0) beat_addr = addr;
                else if (addr !== beat_addr) r_unstable = 1'b1;
                if (stall_cnt < stall) begin
                    stall_cnt++;
                end else begin
                    if (addr !== beat_addr) r_unstable = 1'b1;
                    mem_ready = 1'b1;
                    if (r_xf == 0) r_a0 = addr;
                    else if (r_xf == 1) r_a1 = addr;
                    if (fl_last && r_xf == BEATS - 1) flush = 1'b1;
                    r_xf++;
                    stall_cnt = 0;
                end
            end
            @(posedge clk); #1;
            r_edges++;
            flush = 1'b0;
        end
        r_inst = inst_out;
        mem_ready = 1'b0;
        if (fl_done) begin
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            r_rdy_fl  = ready;
            r_inst_fl = inst_out;
        end
        en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; pc = 8'h42; flush = 1'b0; mem_ready = 1'b1;
        #12;
        total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ready); else passed++;
        total++; if (inst_out !== 16'h0) $display("FAIL reset_inst: got %h want 0000", inst_out); else passed++;
        total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b want 0", mem_req); else passed++;
        total++; if (addr !== 8'h42) $display("FAIL reset_addr: got %h want 42", addr); else passed++;
        en = 1'b0; mem_ready = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_miss();
        do_fetch(8'h10, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== 3) $display("FAIL cold_edges: got %0d want 3", r_edges); else passed++;
        total++; if (r_xf !== 2) $display("FAIL cold_xfers: got %0d want 2", r_xf); else passed++;
        total++; if (r_a0 !== 8'h10 || r_a1 !== 8'h11) $display("FAIL cold_addr: got %h,%h want 10,11", r_a0, r_a1); else passed++;
        total++; if (r_inst !== 16'h1234) $display("FAIL cold_inst: got %h want 1234", r_inst); else passed++;
    endtask

    task automatic test_hit();
        do_fetch(8'h10, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_reqs !== (C ? 0 : 2)) $display("FAIL hit_reqs: got %0d want %0d", r_reqs, C ? 0 : 2); else passed++;
        total++; if (r_edges !== (C ? 1 : 3)) $display("FAIL hit_edges: got %0d want %0d", r_edges, C ? 1 : 3); else passed++;
        total++; if (r_inst !== 16'h1234) $display("FAIL hit_inst: got %h want 1234", r_inst); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL hit_ready_drop: got %b want 0", ready); else passed++;
    endtask

    task automatic test_wrap_stall();
        do_fetch(8'hFF, 3, 1'b0, 1'b0, 1'b0);
        total++; if (r_a0 !== 8'hFF || r_a1 !== 8'h00) $display("FAIL wrap_addr: got %h,%h want ff,00", r_a0, r_a1); else passed++;
        total++; if (r_edges !== 9) $display("FAIL wrap_edges: got %0d want 9", r_edges); else passed++;
        total++; if (r_reqs !== 8) $display("FAIL wrap_reqs: got %0d want 8", r_reqs); else passed++;
        total++; if (r_unstable !== 1'b0) $display("FAIL wrap_addr_stable: got %b want 0", r_unstable); else passed++;
        total++; if (r_inst !== 16'hABCD) $display("FAIL wrap_inst: got %h want abcd", r_inst); else passed++;
        do_fetch(8'hFF, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== (C ? 1 : 3)) $display("FAIL wrap_refetch_edges: got %0d want %0d", r_edges, C ? 1 : 3); else passed++;
    endtask

    task automatic test_abort();
        en = 1'b1; pc = 8'h20; mem_ready = 1'b1;
        @(posedge clk); #1;
        #1;
        total++; if (mem_req !== 1'b1 || addr !== 8'h20) $display("FAIL abort_beat0: got req=%b addr=%h want 1,20", mem_req, addr); else passed++;
        @(posedge clk); #1;
        total++; if (addr !== 8'h21) $display("FAIL abort_beat1_addr: got %h want 21", addr); else passed++;
        en = 1'b0;
        #1;
        total++; if (mem_req !== 1'b0) $display("FAIL abort_req_drop: got %b want 0", mem_req); else passed++;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        total++; if (ready !== 1'b0) $display("FAIL abort_ready: got %b want 0", ready); else passed++;
        total++; if (inst_out !== 16'hABCD) $display("FAIL abort_inst_held: got %h want abcd", inst_out); else passed++;
        do_fetch(8'h20, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== 3 || r_xf !== 2) $display("FAIL abort_refetch: got edges=%0d xf=%0d want 3,2", r_edges, r_xf); else passed++;
        total++; if (r_inst !== 16'h5678) $display("FAIL abort_refetch_inst: got %h want 5678", r_inst); else passed++;
        // 0x20 shares a line with 0x10, so 0x10 must now miss on tag.
        do_fetch(8'h10, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== 3 || r_inst !== 16'h1234) $display("FAIL evict_refetch: got edges=%0d inst=%h want 3,1234", r_edges, r_inst); else passed++;
    endtask

    task automatic test_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        do_fetch(8'h10, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== 3 || r_xf !== 2) $display("FAIL flush_idle_miss: got edges=%0d xf=%0d want 3,2", r_edges, r_xf); else passed++;
        do_fetch(8'h30, 0, 1'b0, 1'b1, 1'b0);
        total++; if (r_inst !== 16'hBC9A) $display("FAIL flush_fill_inst: got %h want bc9a", r_inst); else passed++;
        do_fetch(8'h30, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== 3) $display("FAIL flush_fill_invalid: got edges=%0d want 3", r_edges); else passed++;
        do_fetch(8'h30, 0, 1'b1, 1'b0, 1'b0);
        total++; if (r_edges !== 3) $display("FAIL flush_same_cycle_miss: got edges=%0d want 3", r_edges); else passed++;
        do_fetch(8'h30, 0, 1'b0, 1'b0, 1'b1);
        total++; if (r_edges !== (C ? 1 : 3)) $display("FAIL flush_prefill_hit: got edges=%0d want %0d", r_edges, C ? 1 : 3); else passed++;
        total++; if (r_rdy_fl !== 1'b1 || r_inst_fl !== 16'hBC9A) $display("FAIL flush_in_done: got ready=%b inst=%h want 1,bc9a", r_rdy_fl, r_inst_fl); else passed++;
        do_fetch(8'h30, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_edges !== 3) $display("FAIL flush_done_invalidates: got edges=%0d want 3", r_edges); else passed++;
    endtask

    task automatic test_back_to_back();
        do_fetch(8'h18, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_xf !== 2 || r_inst !== 16'hBEEF) $display("FAIL b2b_first: got xf=%0d inst=%h want 2,beef", r_xf, r_inst); else passed++;
        do_fetch(8'h18, 0, 1'b0, 1'b0, 1'b0);
        total++; if (r_xf !== (C ? 0 : 2)) $display("FAIL b2b_second_xfers: got %0d want %0d", r_xf, C ? 0 : 2); else passed++;
        total++; if (r_inst !== 16'hBEEF) $display("FAIL b2b_second_inst: got %h want beef", r_inst); else passed++;
    endtask

    task automatic test_async_reset();
        int n = 0;
        en = 1'b1; pc = 8'h10; mem_ready = 1'b1;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        total++; if (ready !== 1'b1) $display("FAIL areset_setup: got ready=%b want 1", ready); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (ready !== 1'b0 || inst_out !== 16'h0) $display("FAIL areset_async: got ready=%b inst=%h want 0,0000", ready, inst_out); else passed++;
        en = 1'b0; mem_ready = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i ^ 8'h5A);
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
        mem[8'hFF] = 8'hCD; mem[8'h00] = 8'hAB;
        mem[8'h20] = 8'h78; mem[8'h21] = 8'h56;
        mem[8'h30] = 8'h9A; mem[8'h31] = 8'hBC;
        mem[8'h18] = 8'hEF; mem[8'h19] = 8'hBE;

        test_reset();
        test_cold_miss();
        test_hit();
        test_wrap_stall();
        test_abort();
        test_flush();
        test_back_to_back();
        test_async_reset();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
